// File: rtl/reg_file_scb.sv
// -----------------------------------------------------------------------------
// reg_file_scb
//
// Integer register file with NREGS x XLEN storage, two combinational read
// ports, one synchronous write port and a hardwired-zero register 0. It also
// keeps a per-register pending-write scoreboard. Decode uses the scoreboard
// to detect hazards against long-latency producers such as loads and
// multi-cycle ALU ops. Decode marks registers busy at issue, and writeback
// clears them when it writes the result.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a same-cycle writeback is forwarded to matching read ports.
//               The busy flag of a matching port is also suppressed, unless a
//               new producer targets the same register in that same cycle.
//   undefined : read ports and busy flags reflect stored state only.
//
// Parameters
//   XLEN   data width of every register and data port
//   NREGS  number of architectural registers (power of two, 2..64)
//   AW     derived index width, $clog2(NREGS)
//
// Ports
//   clk         single clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   regwrite    writeback write enable
//   write_reg   writeback destination index
//   write_data  writeback data
//   read_reg1   read port 1 index
//   read_reg2   read port 2 index
//   read_data1  read port 1 data (combinational)
//   read_data2  read port 2 data (combinational)
//   busy_set    issue of a long-latency producer, marks busy_reg pending
//   busy_reg    destination index of the issuing producer
//   rs1_busy    read_reg1 has a pending write
//   rs2_busy    read_reg2 has a pending write
//   busy_count  number of registers currently marked pending (registered)
// -----------------------------------------------------------------------------
module reg_file_scb #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            regwrite,
  input  logic [AW-1:0]   write_reg,
  input  logic [XLEN-1:0] write_data,
  input  logic [AW-1:0]   read_reg1,
  input  logic [AW-1:0]   read_reg2,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2,
  input  logic            busy_set,
  input  logic [AW-1:0]   busy_reg,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [AW:0]     busy_count
);

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_next;
  logic [AW:0]      busy_pop;
  logic [AW:0]      busy_count_q;

  logic            wr_en;
  logic            set_en;
  logic [XLEN-1:0] stored_data1;
  logic [XLEN-1:0] stored_data2;
  logic            stored_busy1;
  logic            stored_busy2;

  // Writes and scoreboard sets aimed at register 0 are dropped. Register 0
  // is therefore never written and its busy bit is never set.
  always_comb begin
    wr_en  = regwrite && (write_reg != '0);
    set_en = busy_set && (busy_reg != '0);
  end

  // Register storage. Reset clears every entry, including register 0, so
  // the array never holds unknown values once the pipeline has been reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[write_reg] <= write_data;
    end
  end

  // Next busy vector. Writeback clears the destination bit first, and the
  // issue set is applied afterwards. When the same index is both cleared and
  // set, the set wins: a new producer is issuing as the old one retires. A
  // single bit is kept per register, with no nesting count.
  always_comb begin
    busy_next = busy_q;
    if (wr_en) begin
      busy_next[write_reg] = 1'b0;
    end
    if (set_en) begin
      busy_next[busy_reg] = 1'b1;
    end
  end

  // Population count of the next busy vector. Registering this count
  // alongside busy_q keeps busy_count consistent with the scoreboard after
  // every edge, and keeps the adder chain off the output path.
  always_comb begin
    busy_pop = '0;
    for (int i = 0; i < NREGS; i++) begin
      busy_pop = busy_pop + {{AW{1'b0}}, busy_next[i]};
    end
  end

  // Scoreboard state and its registered occupancy count. Reset discards all
  // pending state. Producers still in flight must be flushed by the
  // surrounding pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      busy_q       <= busy_next;
      busy_count_q <= busy_pop;
    end
  end

  assign busy_count = busy_count_q;

  // Stored view of both read ports. Index 0 is gated explicitly so that
  // register 0 reads as zero regardless of the storage contents.
  always_comb begin
    stored_data1 = (read_reg1 == '0) ? '0 : regs[read_reg1];
    stored_data2 = (read_reg2 == '0) ? '0 : regs[read_reg2];
    stored_busy1 = busy_q[read_reg1] && (read_reg1 != '0);
    stored_busy2 = busy_q[read_reg2] && (read_reg2 != '0);
  end

`ifdef REGFILE_BYPASS_EN
  logic hit1;
  logic hit2;
  logic reissue1;
  logic reissue2;

  // Write-to-read forwarding. A port that matches the writeback destination
  // sees the incoming data. Its busy flag drops in the same cycle because the
  // value is now available. A producer issuing to the same register in this
  // cycle keeps the stored flag, since the forwarded value is about to be
  // superseded.
  always_comb begin
    hit1     = wr_en && (write_reg == read_reg1);
    hit2     = wr_en && (write_reg == read_reg2);
    reissue1 = set_en && (busy_reg == read_reg1);
    reissue2 = set_en && (busy_reg == read_reg2);

    read_data1 = hit1 ? write_data : stored_data1;
    read_data2 = hit2 ? write_data : stored_data2;
    rs1_busy   = (hit1 && !reissue1) ? 1'b0 : stored_busy1;
    rs2_busy   = (hit2 && !reissue2) ? 1'b0 : stored_busy2;
  end
`else
  // Without forwarding, the read ports and busy flags show stored state only.
  // A same-cycle read returns the old value, and decode absorbs the extra
  // stall cycle.
  always_comb begin
    read_data1 = stored_data1;
    read_data2 = stored_data2;
    rs1_busy   = stored_busy1;
    rs2_busy   = stored_busy2;
  end
`endif

endmodule

// File: tb/tb_reg_file_scb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_scb
//
// Self-checking bench for reg_file_scb with the default parameters. For each
// cycle, the bench derives the expected combinational outputs from its own
// architectural model and pushes them to a queue. At the falling edge it
// pops that entry and compares it with the DUT outputs. The model is updated
// after the rising edge. Building with REGFILE_BYPASS_EN selects the
// forwarding expectations.
// -----------------------------------------------------------------------------
module tb_reg_file_scb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  typedef struct {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            rs1b;
    logic            rs2b;
    logic [AW:0]     cnt;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            regwrite;
  logic [AW-1:0]   write_reg;
  logic [XLEN-1:0] write_data;
  logic [AW-1:0]   read_reg1;
  logic [AW-1:0]   read_reg2;
  logic [XLEN-1:0] read_data1;
  logic [XLEN-1:0] read_data2;
  logic            busy_set;
  logic [AW-1:0]   busy_reg;
  logic            rs1_busy;
  logic            rs2_busy;
  logic [AW:0]     busy_count;

  logic [XLEN-1:0] model_regs [NREGS];
  bit              model_busy [NREGS];
  exp_t            exp_q [$];

  int tests_run = 0;
  int tests_failed = 0;

  reg_file_scb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk        (clk),
    .rst        (rst),
    .regwrite   (regwrite),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .busy_set   (busy_set),
    .busy_reg   (busy_reg),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .busy_count (busy_count)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Single comparison point: counts each comparison and reports mismatches.
  task automatic checkOutput(input string tag, input logic [XLEN-1:0] got,
                             input logic [XLEN-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs for the inputs currently driven, taken from the model.
  function automatic exp_t predict();
    exp_t e;
    int   pop;
    e.rd1  = (read_reg1 == 0) ? '0 : model_regs[read_reg1];
    e.rd2  = (read_reg2 == 0) ? '0 : model_regs[read_reg2];
    e.rs1b = (read_reg1 != 0) && model_busy[read_reg1];
    e.rs2b = (read_reg2 != 0) && model_busy[read_reg2];
`ifdef REGFILE_BYPASS_EN
    if (regwrite && write_reg != 0 && write_reg == read_reg1) begin
      e.rd1 = write_data;
      if (!(busy_set && busy_reg == read_reg1)) e.rs1b = 1'b0;
    end
    if (regwrite && write_reg != 0 && write_reg == read_reg2) begin
      e.rd2 = write_data;
      if (!(busy_set && busy_reg == read_reg2)) e.rs2b = 1'b0;
    end
`endif
    pop = 0;
    for (int i = 0; i < NREGS; i++) pop += model_busy[i] ? 1 : 0;
    e.cnt = (AW+1)'(pop);
    return e;
  endfunction

  // Architectural update applied at the rising edge with the sampled inputs.
  task automatic modelEdge();
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        model_regs[i] = '0;
        model_busy[i] = 1'b0;
      end
    end else begin
      if (regwrite && write_reg != 0) begin
        model_regs[write_reg] = write_data;
        model_busy[write_reg] = 1'b0;
      end
      if (busy_set && busy_reg != 0) model_busy[busy_reg] = 1'b1;
    end
  endtask

  // One cycle: drive the inputs, push the prediction, check at the falling
  // edge, then advance the model past the rising edge.
  task automatic applyStimulus(input logic r, input logic we,
                               input logic [AW-1:0] wr,
                               input logic [XLEN-1:0] wd,
                               input logic [AW-1:0] r1,
                               input logic [AW-1:0] r2,
                               input logic bs, input logic [AW-1:0] br,
                               input bit chk, input string tag);
    exp_t e;
    rst = r; regwrite = we; write_reg = wr; write_data = wd;
    read_reg1 = r1; read_reg2 = r2; busy_set = bs; busy_reg = br;
    if (chk) exp_q.push_back(predict());
    @(negedge clk);
    if (chk) begin
      e = exp_q.pop_front();
      checkOutput({tag, ".rd1"}, read_data1, e.rd1);
      checkOutput({tag, ".rd2"}, read_data2, e.rd2);
      checkOutput({tag, ".rs1b"}, {31'b0, rs1_busy}, {31'b0, e.rs1b});
      checkOutput({tag, ".rs2b"}, {31'b0, rs2_busy}, {31'b0, e.rs2b});
      checkOutput({tag, ".cnt"}, {26'b0, busy_count}, {26'b0, e.cnt});
    end
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) begin
      model_regs[i] = '0;
      model_busy[i] = 1'b0;
    end
    rst = 1'b1; regwrite = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = '0; read_reg2 = '0; busy_set = 1'b0; busy_reg = '0;
    @(posedge clk);
    #1;

    // Reset dominates a write in the same cycle.
    applyStimulus(1, 1, 5, 32'hDEADBEEF, 5, 0, 1, 6, 0, "rst");
    applyStimulus(0, 0, 0, 0, 5, 6, 0, 0, 1, "after_rst");

    // Writes and busy_set aimed at register 0 are discarded.
    applyStimulus(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 1, "wr_x0");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, "rd_x0");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, "busy_x0");
    checkOutput("x0_direct", read_data1, 32'h0);

    // Basic write, then read on both ports.
    applyStimulus(0, 1, 7, 32'h12345678, 0, 0, 0, 0, 1, "wr7");
    applyStimulus(0, 0, 0, 0, 7, 7, 0, 0, 1, "rd7");
    checkOutput("rd7_direct", read_data2, 32'h12345678);

    // Same-cycle read of a register being written.
    applyStimulus(0, 1, 3, 32'hA5A5A5A5, 0, 3, 0, 0, 1, "bypass3");
    applyStimulus(0, 0, 0, 0, 3, 3, 0, 0, 1, "rd3");

    // Scoreboard lifecycle on register 9.
    applyStimulus(0, 0, 0, 0, 9, 0, 1, 9, 1, "set9");
    applyStimulus(0, 0, 0, 0, 9, 9, 0, 0, 1, "busy9");
    checkOutput("busy9_direct", {31'b0, rs1_busy}, 32'h1);
    applyStimulus(0, 1, 9, 32'h55, 9, 0, 0, 0, 1, "clr9");
    applyStimulus(0, 0, 0, 0, 9, 9, 0, 0, 1, "idle9");
    checkOutput("cnt_zero_direct", {26'b0, busy_count}, 32'h0);

    // Set/clear collision: set wins and the data is still written.
    applyStimulus(0, 0, 0, 0, 4, 0, 1, 4, 1, "set4");
    applyStimulus(0, 1, 4, 32'h44, 4, 4, 1, 4, 1, "collide4");
    applyStimulus(0, 0, 0, 0, 4, 4, 0, 0, 1, "after4");
    checkOutput("collide_data_direct", read_data1, 32'h44);
    checkOutput("collide_cnt_direct", {26'b0, busy_count}, 32'h1);

    // Repeated set of a busy bit does not nest, and a clear of an idle bit is
    // harmless.
    applyStimulus(0, 0, 0, 0, 4, 0, 1, 4, 1, "reset4");
    applyStimulus(0, 1, 12, 32'h0C0C0C0C, 4, 12, 0, 0, 1, "clr_idle12");
    applyStimulus(0, 1, 4, 32'h4444, 4, 12, 0, 0, 1, "clr4");
    applyStimulus(0, 0, 0, 0, 4, 12, 0, 0, 1, "after_clr4");

    // Randomised traffic with frequent port collisions.
    for (int n = 0; n < 300; n++) begin
      applyStimulus(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                    $urandom, AW'($urandom_range(0, 7)),
                    AW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, 31)), 1, "rand");
    end

    // Fill the scoreboard to capacity, then reset mid-operation.
    for (int i = 1; i < NREGS; i++) begin
      applyStimulus(0, 0, 0, 0, AW'(i), 0, 1, AW'(i), 1, "fill");
    end
    applyStimulus(0, 0, 0, 0, 31, 1, 0, 0, 1, "full");
    checkOutput("full_cnt_direct", {26'b0, busy_count}, 32'd31);
    applyStimulus(1, 1, 2, 32'h22, 2, 31, 1, 3, 1, "mid_rst");
    applyStimulus(0, 0, 0, 0, 2, 3, 0, 0, 1, "post_rst");
    checkOutput("post_rst_cnt_direct", {26'b0, busy_count}, 32'h0);

    checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reg_file_scb.md
# reg_file_scb

Parametrised successor to the datapath's integer register file. It is an NREGS x XLEN register file with two combinational read ports, one synchronous write port and a hardwired-zero register 0. It adds a per-register pending-write scoreboard that the decode stage uses to detect hazards against long-latency producers such as loads and multi-cycle ALU ops. It sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

## Interface
Parameters:
- XLEN, 32, data width of every register and data port
- NREGS, 32, number of architectural registers; power of two, 2..64; AW = $clog2(NREGS) is a derived localparam

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- regwrite  in  1  write enable for the writeback port
- write_reg  in  AW  writeback destination index
- write_data  in  XLEN  writeback data
- read_reg1  in  AW  read port 1 index
- read_reg2  in  AW  read port 2 index
- read_data1  out  XLEN  read port 1 data, combinational
- read_data2  out  XLEN  read port 2 data, combinational
- busy_set  in  1  issue of a long-latency producer; marks busy_reg pending
- busy_reg  in  AW  destination index of the issuing producer
- rs1_busy  out  1  read_reg1 has a pending write
- rs2_busy  out  1  read_reg2 has a pending write
- busy_count  out  AW+1  number of registers currently marked pending

## Operation
- Storage: NREGS registers of XLEN bits, plus a busy vector of NREGS bits.
- Write: at a rising edge with regwrite=1 and write_reg!=0, reg[write_reg] <= write_data. A write to index 0 is discarded, and reg[0] reads 0 at all times.
- Read: read_dataN = reg[read_regN]. An index of 0 returns 0.
- Scoreboard set: at a rising edge with busy_set=1 and busy_reg!=0, busy[busy_reg] <= 1. busy_set to index 0 is ignored.
- Scoreboard clear: at a rising edge with regwrite=1 and write_reg!=0, busy[write_reg] <= 0.
- Simultaneous set and clear of the same index: set wins and the bit remains 1. This case is a new producer issuing as the old one retires.
- Setting an already-busy bit leaves it at 1; no nesting count is kept.
- Clearing a non-busy bit is legal and has no effect.
- rsN_busy = busy[read_regN] & (read_regN != 0), adjusted by the bypass rules in Configuration.
- busy_count = popcount(busy) as a registered value, consistent with busy after every edge. Range is 0..NREGS-1.

## Timing
- Reset: at a rising edge with rst=1, every register, every busy bit and busy_count become 0. rst dominates regwrite and busy_set in the same cycle. After reset, read_data1/2=0, rs1/rs2_busy=0 and busy_count=0.
- Reset asserted mid-operation discards all pending scoreboard state. Producers still in flight must be flushed by the surrounding pipeline.
- Write latency: data is visible on a read port in the cycle after the write edge, or in the same cycle when bypass is enabled.
- Scoreboard latency: busy_set raises rsN_busy in the cycle after the edge. The same-cycle busy_set is not forwarded to rsN_busy.
- There is no handshake on any port. Every input is sampled at each rising edge.

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding is enabled.
  - If regwrite=1, write_reg!=0 and write_reg==read_regN, read_dataN = write_data in the same cycle.
  - rsN_busy is forced to 0 for that port in that cycle, unless busy_set targets the same index in the same cycle.
- REGFILE_BYPASS_EN undefined:
  - Reads return only stored values, so a same-cycle read returns the old value.
  - rsN_busy reflects only the stored busy bit.
  - Decode must tolerate one extra stall cycle.

## Test plan
- Reset then read: assert rst for 1 cycle with regwrite=1, write_reg=5, write_data=0xDEADBEEF. After the edge, read_reg1=5 gives read_data1=0 and busy_count=0.
- Write x0: regwrite=1, write_reg=0, write_data=0xFFFFFFFF. Next cycle read_reg1=0 gives 0. A following busy_set with busy_reg=0 leaves rs1_busy=0 and busy_count=0.
- Basic write/read: write 0x12345678 to reg 7, then read via both ports. Both read_data1 and read_data2 give 0x12345678 in the next cycle.
- Same-cycle bypass: write 0xA5A5A5A5 to reg 3 while read_reg2=3.
  - With REGFILE_BYPASS_EN, read_data2=0xA5A5A5A5 in that cycle.
  - Without it, read_data2 shows the old value 0, then 0xA5A5A5A5 the next cycle.
- Scoreboard lifecycle: busy_set on reg 9 gives rs1_busy=1 next cycle (read_reg1=9) and busy_count=1. A later regwrite to reg 9 with 0x55 gives rs1_busy=0 after that edge and busy_count=0.
- Set/clear collision: with reg 4 busy, drive busy_set with busy_reg=4 and regwrite with write_reg=4 in the same cycle. Afterwards rs1_busy=1, busy_count stays 1, and reg 4 holds the written data.
